// File: rtl/arf.sv
// Architectural register file with rename tracking: committed data, rename-valid
// bit and producing ROB tag per register. Optional ARF_RETIRE_BYPASS_EN forwards same-cycle retire to lookups.
module arf #(
  parameter int N_ARF_REGS     = 32,
  parameter int REG_DATA_WIDTH = 32,
  parameter int ROB_ID_WIDTH   = 4
) (
  input  logic                      clk,
  input  logic                      rst_aL,
  input  logic                      dispatch_fire,
  input  logic                      dispatch_dst_valid,
  input  logic [4:0]                dispatch_dst_arf_id,
  input  logic [ROB_ID_WIDTH-1:0]   dispatch_rob_id,
  input  logic [4:0]                src1_arf_id,
  input  logic [4:0]                src2_arf_id,
  output logic                      src1_renamed,
  output logic                      src2_renamed,
  output logic [ROB_ID_WIDTH-1:0]   src1_rob_id,
  output logic [ROB_ID_WIDTH-1:0]   src2_rob_id,
  output logic [REG_DATA_WIDTH-1:0] src1_reg_data,
  output logic [REG_DATA_WIDTH-1:0] src2_reg_data,
  input  logic                      retire,
  input  logic [ROB_ID_WIDTH-1:0]   retire_rob_id,
  input  logic [4:0]                retire_arf_id,
  input  logic [REG_DATA_WIDTH-1:0] retire_reg_data,
  input  logic                      retire_redirect_pc_valid
);

  logic [REG_DATA_WIDTH-1:0] data_q [N_ARF_REGS];
  logic [REG_DATA_WIDTH-1:0] data_d [N_ARF_REGS];
  logic [ROB_ID_WIDTH-1:0]   tag_q  [N_ARF_REGS];
  logic [ROB_ID_WIDTH-1:0]   tag_d  [N_ARF_REGS];
  logic [N_ARF_REGS-1:0]     rn_valid_q;
  logic [N_ARF_REGS-1:0]     rn_valid_d;

  logic dispatch_wr;
  assign dispatch_wr = dispatch_fire && dispatch_dst_valid && !retire_redirect_pc_valid;

  // Register 0 is never written, so its flops stay at their reset value.
  always_comb begin
    for (int i = 0; i < N_ARF_REGS; i++) begin
      data_d[i]     = data_q[i];
      tag_d[i]      = tag_q[i];
      rn_valid_d[i] = rn_valid_q[i];
      if (i != 0) begin
        if (retire && (retire_arf_id == 5'(i))) begin
          data_d[i] = retire_reg_data;
          if (tag_q[i] == retire_rob_id) rn_valid_d[i] = 1'b0;
        end
        // Dispatch is applied after retire so a younger rename survives.
        if (dispatch_wr && (dispatch_dst_arf_id == 5'(i))) begin
          rn_valid_d[i] = 1'b1;
          tag_d[i]      = dispatch_rob_id;
        end
        if (retire_redirect_pc_valid) rn_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      for (int i = 0; i < N_ARF_REGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      rn_valid_q <= '0;
    end else begin
      for (int i = 0; i < N_ARF_REGS; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
      rn_valid_q <= rn_valid_d;
    end
  end

  logic [4:0]                src_id   [2];
  logic                      src_ren  [2];
  logic [ROB_ID_WIDTH-1:0]   src_tag  [2];
  logic [REG_DATA_WIDTH-1:0] src_data [2];

  assign src_id[0] = src1_arf_id;
  assign src_id[1] = src2_arf_id;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      src_ren[s]  = 1'b0;
      src_tag[s]  = '0;
      src_data[s] = '0;
      for (int i = 1; i < N_ARF_REGS; i++) begin
        if (src_id[s] == 5'(i)) begin
          src_ren[s]  = rn_valid_q[i];
          src_tag[s]  = tag_q[i];
          src_data[s] = data_q[i];
`ifdef ARF_RETIRE_BYPASS_EN
          if (retire && (retire_arf_id == 5'(i)) && rn_valid_q[i] &&
              (tag_q[i] == retire_rob_id)) begin
            src_ren[s]  = 1'b0;
            src_data[s] = retire_reg_data;
          end
`endif
        end
      end
      if (!src_ren[s]) src_tag[s] = '0;
    end
  end

  assign src1_renamed  = src_ren[0];
  assign src2_renamed  = src_ren[1];
  assign src1_rob_id   = src_tag[0];
  assign src2_rob_id   = src_tag[1];
  assign src1_reg_data = src_data[0];
  assign src2_reg_data = src_data[1];

endmodule

// File: tb/tb_arf.sv
// Self-checking bench for arf: directed vector table, a reset-mid-operation
// sequence and randomized traffic against a behavioural register model.
module tb_arf;
  logic        clk = 1'b0;
  logic        rst_aL;
  logic        dispatch_fire, dispatch_dst_valid;
  logic [4:0]  dispatch_dst_arf_id;
  logic [3:0]  dispatch_rob_id;
  logic [4:0]  src1_arf_id, src2_arf_id;
  logic        src1_renamed, src2_renamed;
  logic [3:0]  src1_rob_id, src2_rob_id;
  logic [31:0] src1_reg_data, src2_reg_data;
  logic        retire;
  logic [3:0]  retire_rob_id;
  logic [4:0]  retire_arf_id;
  logic [31:0] retire_reg_data;
  logic        retire_redirect_pc_valid;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arf dut (
    .clk(clk), .rst_aL(rst_aL),
    .dispatch_fire(dispatch_fire), .dispatch_dst_valid(dispatch_dst_valid),
    .dispatch_dst_arf_id(dispatch_dst_arf_id), .dispatch_rob_id(dispatch_rob_id),
    .src1_arf_id(src1_arf_id), .src2_arf_id(src2_arf_id),
    .src1_renamed(src1_renamed), .src2_renamed(src2_renamed),
    .src1_rob_id(src1_rob_id), .src2_rob_id(src2_rob_id),
    .src1_reg_data(src1_reg_data), .src2_reg_data(src2_reg_data),
    .retire(retire), .retire_rob_id(retire_rob_id), .retire_arf_id(retire_arf_id),
    .retire_reg_data(retire_reg_data), .retire_redirect_pc_valid(retire_redirect_pc_valid)
  );

  typedef struct {
    logic        fire, dv;
    logic [4:0]  dst;
    logic [3:0]  drob;
    logic [4:0]  s1, s2;
    logic        ret;
    logic [3:0]  rrob;
    logic [4:0]  rarf;
    logic [31:0] rdata;
    logic        redir;
    logic        e1r;
    logic [3:0]  e1t;
    logic [31:0] e1d;
    logic        e2r;
    logic [3:0]  e2t;
    logic [31:0] e2d;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: plain per-register arrays.
  logic [31:0] m_data [32];
  logic        m_rv   [32];
  logic [3:0]  m_tag  [32];

  function automatic vec_t mk(logic fire, logic dv, logic [4:0] dst, logic [3:0] drob,
                              logic [4:0] s1, logic [4:0] s2, logic ret, logic [3:0] rrob,
                              logic [4:0] rarf, logic [31:0] rdata, logic redir,
                              logic e1r, logic [3:0] e1t, logic [31:0] e1d,
                              logic e2r, logic [3:0] e2t, logic [31:0] e2d);
    vec_t v;
    v.fire = fire; v.dv = dv; v.dst = dst; v.drob = drob; v.s1 = s1; v.s2 = s2;
    v.ret = ret; v.rrob = rrob; v.rarf = rarf; v.rdata = rdata; v.redir = redir;
    v.e1r = e1r; v.e1t = e1t; v.e1d = e1d; v.e2r = e2r; v.e2t = e2t; v.e2d = e2d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    dispatch_fire = v.fire; dispatch_dst_valid = v.dv;
    dispatch_dst_arf_id = v.dst; dispatch_rob_id = v.drob;
    src1_arf_id = v.s1; src2_arf_id = v.s2;
    retire = v.ret; retire_rob_id = v.rrob; retire_arf_id = v.rarf;
    retire_reg_data = v.rdata; retire_redirect_pc_valid = v.redir;
  endtask

  task automatic check_src(input string tag, input logic er, input logic [3:0] et,
                           input logic [31:0] ed, input logic ar, input logic [3:0] at,
                           input logic [31:0] ad);
    chk({tag, "_renamed"}, {31'd0, ar}, {31'd0, er});
    if (er) chk({tag, "_rob_id"}, {28'd0, at}, {28'd0, et});
    else    chk({tag, "_data"}, ad, ed);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0; m_rv[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  task automatic model_lookup(input logic [4:0] id, output logic r, output logic [3:0] t,
                              output logic [31:0] d);
    r = 1'b0; t = '0; d = '0;
    if (id != 0) begin
      r = m_rv[id]; t = m_tag[id]; d = m_data[id];
`ifdef ARF_RETIRE_BYPASS_EN
      if (retire && retire_arf_id == id && m_rv[id] && m_tag[id] == retire_rob_id) begin
        r = 1'b0; d = retire_reg_data;
      end
`endif
    end
  endtask

  function automatic void model_step();
    if (retire && retire_arf_id != 0) begin
      m_data[retire_arf_id] = retire_reg_data;
      if (m_tag[retire_arf_id] == retire_rob_id) m_rv[retire_arf_id] = 1'b0;
    end
    if (retire_redirect_pc_valid) begin
      for (int i = 0; i < 32; i++) m_rv[i] = 1'b0;
    end else if (dispatch_fire && dispatch_dst_valid && dispatch_dst_arf_id != 0) begin
      m_rv[dispatch_dst_arf_id]  = 1'b1;
      m_tag[dispatch_dst_arf_id] = dispatch_rob_id;
    end
  endfunction

  initial begin
    vec_t idle;
    logic er; logic [3:0] et; logic [31:0] ed;

    idle = mk(0,0,0,0, 0,0, 0,0,0,0, 0, 0,0,0, 0,0,0);
    //        fire dv dst drob s1 s2 ret rrob rarf rdata redir | e1 r,t,d | e2 r,t,d
    vecs.push_back(mk(0,0,0,0,  5,0,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,5,  1,0,0,32'hFFFF,      0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,5,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(1,1,3,7,  3,0,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  3,0,  0,0,0,0,             0, 1,7,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,  1,7,3,32'hDEADBEEF,  0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  3,0,  0,0,0,0,             0, 0,0,32'hDEADBEEF, 0,0,0));
    vecs.push_back(mk(1,1,3,2,  3,0,  0,0,0,0,             0, 0,0,32'hDEADBEEF, 0,0,0));
    vecs.push_back(mk(1,1,3,9,  3,0,  0,0,0,0,             0, 1,2,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  3,0,  1,2,3,32'h11,        0, 1,9,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  3,0,  0,0,0,0,             0, 1,9,0,            0,0,0));
    vecs.push_back(mk(1,1,4,5,  4,0,  1,1,4,32'h22,        0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  4,3,  0,0,0,0,             0, 1,5,0,            1,9,0));
    vecs.push_back(mk(1,1,6,10, 0,0,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(1,1,7,11, 6,0,  0,0,0,0,             0, 1,10,0,           0,0,0));
    vecs.push_back(mk(1,1,8,3,  6,7,  0,0,0,0,             1, 1,10,0,           1,11,0));
    vecs.push_back(mk(0,0,0,0,  6,7,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  8,3,  0,0,0,0,             0, 0,0,0,            0,0,32'h11));
    vecs.push_back(mk(1,1,9,4,  4,0,  0,0,0,0,             0, 0,0,32'h22,       0,0,0));
`ifdef ARF_RETIRE_BYPASS_EN
    vecs.push_back(mk(0,0,0,0,  9,9,  1,4,9,32'h55,        0, 0,0,32'h55,       0,0,32'h55));
`else
    vecs.push_back(mk(0,0,0,0,  9,9,  1,4,9,32'h55,        0, 1,4,0,            1,4,0));
`endif
    vecs.push_back(mk(0,0,0,0,  9,0,  0,0,0,0,             0, 0,0,32'h55,       0,0,0));
    vecs.push_back(mk(1,1,0,6,  0,0,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  0,0,  0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(1,0,10,5, 10,0, 0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,1,11,5, 10,11,0,0,0,0,             0, 0,0,0,            0,0,0));
    vecs.push_back(mk(0,0,0,0,  11,0, 0,0,0,0,             0, 0,0,0,            0,0,0));

    rst_aL = 1'b0;
    drive(vecs[0]);
    #1;
    check_src("reset_src1", 1'b0, 4'd0, 32'd0, src1_renamed, src1_rob_id, src1_reg_data);
    chk("reset_src1_rob_id", {28'd0, src1_rob_id}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_aL = 1'b1;

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      check_src($sformatf("vec%0d_src1", k), vecs[k].e1r, vecs[k].e1t, vecs[k].e1d,
                src1_renamed, src1_rob_id, src1_reg_data);
      check_src($sformatf("vec%0d_src2", k), vecs[k].e2r, vecs[k].e2t, vecs[k].e2d,
                src2_renamed, src2_rob_id, src2_reg_data);
    end

    // Reset asserted mid-operation with a dispatch and retire in flight.
    @(negedge clk);
    drive(mk(1,1,12,1, 3,12, 1,0,13,32'hAA, 0, 0,0,0, 0,0,0));
    #2;
    rst_aL = 1'b0;
    #1;
    check_src("midrst_x3", 1'b0, 4'd0, 32'd0, src1_renamed, src1_rob_id, src1_reg_data);
    @(posedge clk);
    #1;
    drive(idle);
    rst_aL = 1'b1;
    src1_arf_id = 5'd12; src2_arf_id = 5'd13;
    #1;
    check_src("postrst_x12", 1'b0, 4'd0, 32'd0, src1_renamed, src1_rob_id, src1_reg_data);
    check_src("postrst_x13", 1'b0, 4'd0, 32'd0, src2_renamed, src2_rob_id, src2_reg_data);
    model_reset();

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      dispatch_fire            = ($urandom_range(0, 99) < 60);
      dispatch_dst_valid       = ($urandom_range(0, 99) < 80);
      dispatch_dst_arf_id      = 5'($urandom_range(0, 7));
      dispatch_rob_id          = 4'($urandom);
      src1_arf_id              = 5'($urandom_range(0, 7));
      src2_arf_id              = 5'($urandom_range(0, 7));
      retire                   = ($urandom_range(0, 99) < 50);
      retire_arf_id            = 5'($urandom_range(0, 7));
      retire_rob_id            = ($urandom_range(0, 99) < 60) ? m_tag[retire_arf_id] : 4'($urandom);
      retire_reg_data          = $urandom;
      retire_redirect_pc_valid = ($urandom_range(0, 99) < 5);
      #1;
      model_lookup(src1_arf_id, er, et, ed);
      check_src("rand_src1", er, et, ed, src1_renamed, src1_rob_id, src1_reg_data);
      model_lookup(src2_arf_id, er, et, ed);
      check_src("rand_src2", er, et, ed, src2_renamed, src2_rob_id, src2_reg_data);
      @(posedge clk);
      model_step();
    end

    @(negedge clk);
    drive(idle);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
